// File: rtl/keypad_cmd_if.sv
// Press-command channel between the test sequencer and the keypad emulator.
interface keypad_cmd_if #(
  parameter int HOLD_W = 24
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_key;
  logic [HOLD_W-1:0] cmd_hold;

  modport master (
    output cmd_valid,
    output cmd_key,
    output cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_key,
    input  cmd_hold,
    output cmd_ready
  );
endinterface

// File: rtl/keypad_matrix_emulator.sv
// Emulates one key of a 4x4 passive matrix keypad: scripted press with bounce,
// hold, release bounce and an inter-key gap, answering the scanner's column strobes.
module keypad_matrix_emulator #(
  parameter logic [15:0] BOUNCE_CYCLES = 16'd64,
  parameter logic [15:0] GAP_CYCLES    = 16'd32,
  parameter int          HOLD_W        = 24,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               resetn,
  keypad_cmd_if.slave        cmdIf,
  input  logic [3:0]         key_col,
  output logic [3:0]         key_row,
  output logic               contact,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_DN,
    S_HOLD,
    S_BOUNCE_UP,
    S_GAP
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [15:0]       r_cnt;
  logic [15:0]       w_cntNext;
  logic [HOLD_W-1:0] r_holdCnt;
  logic [HOLD_W-1:0] w_holdCntNext;
  logic [HOLD_W-1:0] w_holdLoad;
  logic [15:0]       r_lfsr;
  logic              w_lfsrFb;
  logic              w_inBounce;
  logic [3:0]        r_key;
  logic [3:0]        r_keyRow;
  logic [3:0]        w_rowN;
  logic              w_accept;
  logic              w_contact;
  logic              w_done;

  assign w_accept   = cmdIf.cmd_valid && (r_state == S_IDLE);
  assign w_inBounce = (r_state == S_BOUNCE_DN) || (r_state == S_BOUNCE_UP);
  assign w_lfsrFb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  // A requested hold of 0 still gives one stable-closed cycle.
  assign w_holdLoad = (cmdIf.cmd_hold == '0) ? '0 : (cmdIf.cmd_hold - HOLD_W'(1));

  assign cmdIf.cmd_ready = (r_state == S_IDLE);
  assign busy            = (r_state != S_IDLE);
  assign contact         = w_contact;
  assign done            = w_done;
  assign key_row         = r_keyRow;

  // Next-state, dwell counters and contact; zero-length bounce/gap phases are skipped.
  always_comb begin
    w_nextState   = r_state;
    w_cntNext     = r_cnt;
    w_holdCntNext = r_holdCnt;
    w_contact     = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_holdCntNext = w_holdLoad;
          if (BOUNCE_CYCLES != 16'd0) begin
            w_nextState = S_BOUNCE_DN;
            w_cntNext   = BOUNCE_CYCLES - 16'd1;
          end else begin
            w_nextState = S_HOLD;
          end
        end
      end
      S_BOUNCE_DN: begin
        w_contact = r_lfsr[0];
        if (r_cnt == 16'd0) begin
          w_nextState = S_HOLD;
        end else begin
          w_cntNext = r_cnt - 16'd1;
        end
      end
      S_HOLD: begin
        w_contact = 1'b1;
        if (r_holdCnt == '0) begin
          if (BOUNCE_CYCLES != 16'd0) begin
            w_nextState = S_BOUNCE_UP;
            w_cntNext   = BOUNCE_CYCLES - 16'd1;
          end else if (GAP_CYCLES != 16'd0) begin
            w_nextState = S_GAP;
            w_cntNext   = GAP_CYCLES - 16'd1;
          end else begin
            w_nextState = S_IDLE;
            w_done      = 1'b1;
          end
        end else begin
          w_holdCntNext = r_holdCnt - HOLD_W'(1);
        end
      end
      S_BOUNCE_UP: begin
        w_contact = r_lfsr[0];
        if (r_cnt == 16'd0) begin
          if (GAP_CYCLES != 16'd0) begin
            w_nextState = S_GAP;
            w_cntNext   = GAP_CYCLES - 16'd1;
          end else begin
            w_nextState = S_IDLE;
            w_done      = 1'b1;
          end
        end else begin
          w_cntNext = r_cnt - 16'd1;
        end
      end
      S_GAP: begin
        if (r_cnt == 16'd0) begin
          w_nextState = S_IDLE;
          w_done      = 1'b1;
        end else begin
          w_cntNext = r_cnt - 16'd1;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Pull the latched key's row low only while closed and its column is strobed.
  always_comb begin
    w_rowN = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      w_rowN[r] = ~(w_contact && (2'(r) == r_key[3:2]) && ~key_col[r_key[1:0]]);
    end
  end

  // State register, dwell counters and the key latched at accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_holdCnt <= '0;
      r_key     <= '0;
    end else begin
      r_state   <= w_nextState;
      r_cnt     <= w_cntNext;
      r_holdCnt <= w_holdCntNext;
      if (w_accept) begin
        r_key <= cmdIf.cmd_key;
      end
    end
  end

  // Bounce noise source; frozen outside the bounce windows.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_inBounce) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsrFb};
    end
  end

  // Registered row lines give the scanner a one-cycle response latency.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_keyRow <= 4'b1111;
    end else begin
      r_keyRow <= w_rowN;
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator: one instance without bounce (short gap)
// and one with the default bounce/gap timing.
module tb_keypad_matrix_emulator;

  localparam int          HW   = 24;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] colA   = 4'b1111;
  logic [3:0] colB   = 4'b1111;
  logic [3:0] rowA, rowB;
  logic       contactA, busyA, doneA;
  logic       contactB, busyB, doneB;

  int compared   = 0;
  int mismatched = 0;

  keypad_cmd_if #(.HOLD_W(HW)) ifA ();
  keypad_cmd_if #(.HOLD_W(HW)) ifB ();

  keypad_matrix_emulator #(
    .BOUNCE_CYCLES(16'd0),
    .GAP_CYCLES   (16'd4),
    .HOLD_W       (HW),
    .LFSR_SEED    (SEED)
  ) dutA (
    .clk    (clk),
    .resetn (resetn),
    .cmdIf  (ifA),
    .key_col(colA),
    .key_row(rowA),
    .contact(contactA),
    .busy   (busyA),
    .done   (doneA)
  );

  keypad_matrix_emulator #(
    .BOUNCE_CYCLES(16'd64),
    .GAP_CYCLES   (16'd32),
    .HOLD_W       (HW),
    .LFSR_SEED    (SEED)
  ) dutB (
    .clk    (clk),
    .resetn (resetn),
    .cmdIf  (ifB),
    .key_col(colB),
    .key_row(rowB),
    .contact(contactB),
    .busy   (busyB),
    .done   (doneB)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Issue one command to instance A; returns at the first negedge after the accept.
  task automatic applyStimulus(input logic [3:0] key, input logic [HW-1:0] hold);
    ifA.cmd_valid = 1'b1;
    ifA.cmd_key   = key;
    ifA.cmd_hold  = hold;
    @(negedge clk);
    ifA.cmd_valid = 1'b0;
  endtask

  // Wait, bounded, for instance A to return to idle.
  task automatic waitIdleA(input int budget);
    int n = 0;
    while (!ifA.cmd_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("A idle wait", 32'(ifA.cmd_ready), 32'd1);
  endtask

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0]  expRow;
    logic [15:0] lf;
    logic        expC, prevC;
    logic [3:0]  kv;
    int          doneCount;
    int          hB;

    ifA.cmd_valid = 1'b1; ifA.cmd_key = 4'd3; ifA.cmd_hold = '0;
    ifB.cmd_valid = 1'b1; ifB.cmd_key = 4'd3; ifB.cmd_hold = '0;

    // T1: reset held with valid asserted
    repeat (3) @(negedge clk);
    checkOutput("T1 rowA", 32'(rowA), 32'hF);
    checkOutput("T1 rowB", 32'(rowB), 32'hF);
    checkOutput("T1 readyA", 32'(ifA.cmd_ready), 32'd1);
    checkOutput("T1 busyA", 32'(busyA), 32'd0);
    checkOutput("T1 busyB", 32'(busyB), 32'd0);
    checkOutput("T1 contactB", 32'(contactB), 32'd0);
    ifA.cmd_valid = 1'b0;
    ifB.cmd_valid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("T1 busyA after", 32'(busyA), 32'd0);

    // T2: key 6, hold 100, no bounce; column 2 strobed except cycles 40..49
    colA = 4'b1011;
    applyStimulus(4'd6, 24'd100);
    for (int c = 0; c <= 105; c++) begin
      expRow = (c >= 1 && c <= 100 && !(c - 1 >= 40 && c - 1 < 50)) ? 4'b1101 : 4'b1111;
      checkOutput($sformatf("T2 row c%0d", c), 32'(rowA), 32'(expRow));
      checkOutput($sformatf("T2 done c%0d", c), 32'(doneA), 32'(c == 103));
      if (c == 104) checkOutput("T2 ready", 32'(ifA.cmd_ready), 32'd1);
      colA = (c >= 40 && c < 50) ? 4'b1101 : 4'b1011;
      @(negedge clk);
    end

    // T3: key 15 with bounce on instance B, all columns strobed
    hB = 10;
    colB = 4'b0000;
    ifB.cmd_valid = 1'b1; ifB.cmd_key = 4'd15; ifB.cmd_hold = 24'(hB);
    @(negedge clk);
    ifB.cmd_valid = 1'b0;
    lf = SEED; prevC = 1'b0; doneCount = 0;
    for (int c = 0; c <= 160 + hB; c++) begin
      if (c < 64)            expC = lf[0];
      else if (c < 64 + hB)  expC = 1'b1;
      else if (c < 128 + hB) expC = lf[0];
      else                   expC = 1'b0;
      checkOutput($sformatf("T3 contact c%0d", c), 32'(contactB), 32'(expC));
      checkOutput($sformatf("T3 row c%0d", c), 32'(rowB), 32'({~prevC, 3'b111}));
      checkOutput($sformatf("T3 done c%0d", c), 32'(doneB), 32'(c == 159 + hB));
      checkOutput($sformatf("T3 busy c%0d", c), 32'(busyB), 32'(c < 160 + hB));
      if (doneB) doneCount++;
      if (c < 64 || (c >= 64 + hB && c < 128 + hB)) lf = lfsrStep(lf);
      prevC = expC;
      @(negedge clk);
    end
    checkOutput("T3 done count", 32'(doneCount), 32'd1);

    // T4: valid held across two commands (key 0 then key 9)
    colA = 4'b1110;
    ifA.cmd_valid = 1'b1; ifA.cmd_key = 4'd0; ifA.cmd_hold = 24'd3;
    @(negedge clk);
    ifA.cmd_key = 4'd9; ifA.cmd_hold = 24'd2;
    for (int c = 0; c <= 9; c++) begin
      if (c <= 6) begin
        checkOutput($sformatf("T4 ready c%0d", c), 32'(ifA.cmd_ready), 32'd0);
        checkOutput($sformatf("T4 busy c%0d", c), 32'(busyA), 32'd1);
      end
      checkOutput($sformatf("T4 done c%0d", c), 32'(doneA), 32'(c == 6));
      if (c == 1) begin
        checkOutput("T4 key0 row", 32'(rowA), 32'b1110);
        colA = 4'b1101;
      end
      if (c == 7) checkOutput("T4 ready after done", 32'(ifA.cmd_ready), 32'd1);
      if (c == 8) begin
        checkOutput("T4 second accept", 32'(busyA), 32'd1);
        ifA.cmd_valid = 1'b0;
      end
      if (c == 9) checkOutput("T4 key9 row", 32'(rowA), 32'b1011);
      @(negedge clk);
    end
    waitIdleA(20);

    // T5: zero hold gives a single closed cycle
    colA = 4'b1101;
    applyStimulus(4'd5, 24'd0);
    checkOutput("T5 contact c0", 32'(contactA), 32'd1);
    @(negedge clk);
    checkOutput("T5 contact c1", 32'(contactA), 32'd0);
    checkOutput("T5 row c1", 32'(rowA), 32'b1101);
    @(negedge clk);
    checkOutput("T5 row c2", 32'(rowA), 32'b1111);
    waitIdleA(20);

    // T5: reset in the middle of a hold
    applyStimulus(4'd5, 24'd50);
    @(negedge clk);
    @(negedge clk);
    checkOutput("T5 row before reset", 32'(rowA), 32'b1101);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("T5 row after reset", 32'(rowA), 32'hF);
    checkOutput("T5 ready after reset", 32'(ifA.cmd_ready), 32'd1);
    checkOutput("T5 busy after reset", 32'(busyA), 32'd0);
    checkOutput("T5 contact after reset", 32'(contactA), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("T5 busy after release", 32'(busyA), 32'd0);

    // T6: each of the 16 keys answers only on its own row when its column is strobed
    for (int k = 0; k < 16; k++) begin
      kv = 4'(k);
      colA = 4'b1111 ^ (4'b0001 << kv[1:0]);
      applyStimulus(kv, 24'd4);
      @(negedge clk);
      checkOutput($sformatf("T6 row key%0d", k), 32'(rowA), 32'(4'b1111 ^ (4'b0001 << kv[3:2])));
      waitIdleA(30);
      checkOutput($sformatf("T6 released key%0d", k), 32'(rowA), 32'hF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
